// File: rtl/scroll_sequencer_if.sv
// ---------------------------------------------------------------------------
// scroll_sequencer_if
//
// Command channel between the display control logic (master) and the
// scroll sequencer (slave). One command is transferred on each clock where
// cmd_valid and cmd_ready are both high.
//
// Signals
//   cmd_valid    master -> slave  command offered
//   cmd_ready    slave  -> master sequencer can take a command
//   cmd_pattern  master -> slave  initial rotator contents (SIZE bits)
//   cmd_dir      master -> slave  1 = shift toward MSB, 0 = toward LSB
//   cmd_steps    master -> slave  steps to run, 0 = run until abort (STEP_W bits)
//   cmd_bounce   master -> slave  ping-pong request (only honoured when the
//                                 sequencer is built with SCROLL_BOUNCE_EN)
// ---------------------------------------------------------------------------
interface scroll_sequencer_if #(
  parameter int SIZE   = 4,
  parameter int STEP_W = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [SIZE-1:0]   cmd_pattern;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_bounce;

  // Control logic side: offers commands, watches ready
  modport master (
    output cmd_valid,
    output cmd_pattern,
    output cmd_dir,
    output cmd_steps,
    output cmd_bounce,
    input  cmd_ready
  );

  // Sequencer side: takes commands, reports ready
  modport slave (
    input  cmd_valid,
    input  cmd_pattern,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_bounce,
    output cmd_ready
  );

endinterface

// File: rtl/scroll_sequencer.sv
// ---------------------------------------------------------------------------
// scroll_sequencer
//
// Drives a SIZE-bit circular-shift register (rotator) for display scrolling.
// A command (pattern, direction, step count) is taken over the cmd interface,
// the pattern is loaded through the rotator's active-low load pin, and then
// one-cycle step enables are issued every PRESCALE clocks until the step
// count completes, an abort arrives, or forever when the step count is 0.
//
// Parameters
//   SIZE      rotator width in bits (>= 2)
//   PRESCALE  clk cycles per rotation step (>= 2)
//   PRE_W     prescaler width, 2**PRE_W must exceed PRESCALE
//   STEP_W    step-count width
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   cmd         slave modport of scroll_sequencer_if (command handshake)
//   pause       in   level, freezes prescaler and stepping while running
//   abort       in   pulse, ends the scroll and returns to idle
//   rot_load_n  out  rotator load/reset pin, low = load rot_load
//   rot_load    out  rotator load bus
//   rot_en      out  rotator step enable, one-cycle pulse per step
//   rot_dir     out  rotator direction
//   busy        out  high while loading or running
//   done        out  one-cycle pulse when the step count completes
//
// Build option
//   SCROLL_BOUNCE_EN  when defined, a command with cmd_bounce set flips
//                     rot_dir after every SIZE-th step (ping-pong scroll).
//                     When undefined cmd_bounce is ignored.
// ---------------------------------------------------------------------------
module scroll_sequencer #(
  parameter int SIZE     = 4,
  parameter int PRESCALE = 50000,
  parameter int PRE_W    = 16,
  parameter int STEP_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  scroll_sequencer_if.slave   cmd,
  input  logic                pause,
  input  logic                abort,
  output logic                rot_load_n,
  output logic [SIZE-1:0]     rot_load,
  output logic                rot_en,
  output logic                rot_dir,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [1:0]        state;
  logic [PRE_W-1:0]  presc;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] steps_q;
  logic              accept;
  logic              last_step;

`ifdef SCROLL_BOUNCE_EN
  localparam int TOG_W = $clog2(SIZE);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(SIZE - 1);

  logic              bounce_q;
  logic [TOG_W-1:0]  tog_cnt;
`else
  logic              unused_bounce;
  assign unused_bounce = cmd.cmd_bounce;
`endif

  // Handshake and status are decoded straight from the state so the master
  // sees ready in the same cycle the sequencer becomes idle.
  assign cmd.cmd_ready = (state == S_IDLE);
  assign busy          = (state == S_LOAD) || (state == S_RUN);
  assign accept        = cmd.cmd_valid && (state == S_IDLE);

  // The step pulse that reaches the programmed count is still on rot_en in
  // this cycle; step_cnt has already been advanced to include it. Finishing
  // here puts done one cycle after the last pulse.
  assign last_step = rot_en && (steps_q != '0) && (step_cnt == steps_q);

  // Main sequencer. rot_en and done default low every cycle so they can only
  // ever be single-cycle pulses. The accept edge clears the prescaler so it
  // reads 0 during LOAD; LOAD itself counts as the first prescale tick, which
  // places the first step exactly PRESCALE cycles after LOAD. Abort is tested
  // first in every active state so it beats both a pending step and DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      presc      <= '0;
      step_cnt   <= '0;
      steps_q    <= '0;
      rot_load_n <= 1'b0;
      rot_load   <= '0;
      rot_en     <= 1'b0;
      rot_dir    <= 1'b0;
      done       <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
      bounce_q   <= 1'b0;
      tog_cnt    <= '0;
`endif
    end else begin
      rot_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          rot_load_n <= 1'b1;
          if (accept) begin
            state      <= S_LOAD;
            rot_load_n <= 1'b0;
            rot_load   <= cmd.cmd_pattern;
            rot_dir    <= cmd.cmd_dir;
            steps_q    <= cmd.cmd_steps;
            presc      <= '0;
            step_cnt   <= '0;
`ifdef SCROLL_BOUNCE_EN
            bounce_q   <= cmd.cmd_bounce;
`endif
          end
        end
        S_LOAD: begin
          rot_load_n <= 1'b1;
          presc      <= presc + PRE_W'(1);
`ifdef SCROLL_BOUNCE_EN
          tog_cnt    <= '0;
`endif
          state      <= abort ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (last_step) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (!pause) begin
            if (presc == PRE_LAST) begin
              presc    <= '0;
              rot_en   <= 1'b1;
              step_cnt <= step_cnt + STEP_W'(1);
            end else begin
              presc <= presc + PRE_W'(1);
            end
          end
`ifdef SCROLL_BOUNCE_EN
          if (!abort && rot_en && bounce_q) begin
            if (tog_cnt == TOG_LAST) begin
              tog_cnt <= '0;
              rot_dir <= ~rot_dir;
            end else begin
              tog_cnt <= tog_cnt + TOG_W'(1);
            end
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scroll_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scroll_sequencer
//
// Self-checking bench for scroll_sequencer (SIZE=4, PRESCALE=4, STEP_W=8)
// with a behavioural rotator attached to the rot_* outputs. A table of
// commands with hand-computed results is run first, followed by hand-written
// sequences for continuous scroll + abort, abort during LOAD and reset in
// the middle of a scroll. Expected ping-pong behaviour follows the
// SCROLL_BOUNCE_EN build option.
// ---------------------------------------------------------------------------
module tb_scroll_sequencer;

  localparam int SIZE     = 4;
  localparam int PRESCALE = 4;
  localparam int PRE_W    = 16;
  localparam int STEP_W   = 8;

`ifdef SCROLL_BOUNCE_EN
  localparam bit BOUNCE_BUILT = 1'b1;
`else
  localparam bit BOUNCE_BUILT = 1'b0;
`endif

  typedef struct {
    logic [3:0] pattern;
    logic       dir;
    logic [7:0] steps;
    logic       bounce;
    int         pause_at;
    int         pause_len;
    logic       hold_valid;
    int         exp_first;
    logic [3:0] exp_final;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            pause;
  logic            abort;
  logic            rot_load_n;
  logic [SIZE-1:0] rot_load;
  logic            rot_en;
  logic            rot_dir;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] rot;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[9];

  scroll_sequencer_if #(.SIZE(SIZE), .STEP_W(STEP_W)) cmd_if ();

  scroll_sequencer #(
    .SIZE(SIZE),
    .PRESCALE(PRESCALE),
    .PRE_W(PRE_W),
    .STEP_W(STEP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd(cmd_if),
    .pause(pause),
    .abort(abort),
    .rot_load_n(rot_load_n),
    .rot_load(rot_load),
    .rot_en(rot_en),
    .rot_dir(rot_dir),
    .busy(busy),
    .done(done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Rotator model: async active-low load, circular shift on enable
  always @(posedge clk or negedge rot_load_n) begin
    if (!rot_load_n)
      rot <= rot_load;
    else if (rot_en)
      rot <= rot_dir ? {rot[SIZE-2:0], rot[SIZE-1]} : {rot[0], rot[SIZE-1:1]};
  end

  // Safety net in case some bounded loop is broken
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Waits (bounded) for ready, offers one command, returns in the LOAD cycle
  task automatic applyStimulus(input logic [3:0] pat, input logic dir,
                               input logic [7:0] steps, input logic bounce);
    for (int i = 0; i < 50 && !cmd_if.cmd_ready; i++) tick();
    checkOutput("ready_wait", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_pattern = pat;
    cmd_if.cmd_dir     = dir;
    cmd_if.cmd_steps   = steps;
    cmd_if.cmd_bounce  = bounce;
    tick();
    cmd_if.cmd_valid   = 1'b0;
  endtask

  // Runs one table entry, cycle numbers counted from the LOAD cycle (0)
  task automatic runVector(input int idx, input vec_t v);
    int c, pulses, first, last, done_at, flip_after, extra_load, ready_busy;
    bit spacing_ok;
    logic [3:0] rot_at_done;
    c = 0; pulses = 0; first = -1; last = -1; done_at = -1; flip_after = -1;
    extra_load = 0; ready_busy = 0; spacing_ok = 1'b1; rot_at_done = 'x;
    applyStimulus(v.pattern, v.dir, v.steps, v.bounce);
    pause = (c >= v.pause_at) && (c < v.pause_at + v.pause_len);
    checkOutput($sformatf("v%0d_load_n_low", idx), rot_load_n, 0);
    checkOutput($sformatf("v%0d_busy_load", idx), busy, 1);
    if (v.hold_valid) begin
      cmd_if.cmd_valid   = 1'b1;
      cmd_if.cmd_pattern = 4'b1111;
      cmd_if.cmd_dir     = ~v.dir;
      cmd_if.cmd_steps   = 8'd1;
    end
    while (done_at < 0 && c < 300) begin
      tick();
      c++;
      pause = (c >= v.pause_at) && (c < v.pause_at + v.pause_len);
      if (c == 1) checkOutput($sformatf("v%0d_loaded", idx), rot, v.pattern);
      if (!rot_load_n) extra_load++;
      if (cmd_if.cmd_ready) ready_busy++;
      if (rot_en) begin
        if (pulses == 0) first = c;
        else if (c - last != PRESCALE) spacing_ok = 1'b0;
        last = c;
        pulses++;
      end
      if (rot_dir !== v.dir && flip_after < 0) flip_after = pulses;
      if (done) begin
        done_at = c;
        rot_at_done = rot;
        cmd_if.cmd_valid = 1'b0;
      end
    end
    pause = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    checkOutput($sformatf("v%0d_first_pulse", idx), first, v.exp_first);
    checkOutput($sformatf("v%0d_pulse_count", idx), pulses, v.steps);
    checkOutput($sformatf("v%0d_spacing", idx), spacing_ok, 1);
    checkOutput($sformatf("v%0d_done_time", idx), done_at, last + 1);
    checkOutput($sformatf("v%0d_final_rot", idx), rot_at_done, v.exp_final);
    checkOutput($sformatf("v%0d_load_n_once", idx), extra_load, 0);
    checkOutput($sformatf("v%0d_ready_busy", idx), ready_busy, 0);
    checkOutput($sformatf("v%0d_rot_load_held", idx), rot_load, v.pattern);
    checkOutput($sformatf("v%0d_dir_flip", idx), flip_after,
                (v.bounce && BOUNCE_BUILT) ? 4 : -1);
    tick();
    checkOutput($sformatf("v%0d_done_width", idx), done, 0);
    checkOutput($sformatf("v%0d_ready_after", idx), cmd_if.cmd_ready, 1);
    checkOutput($sformatf("v%0d_en_after", idx), rot_en, 0);
  endtask

  // Stimulus and checking sequence
  initial begin
    int c, pulses, stray;

    //            pattern  dir   steps  bnc   p_at p_len hold  first final
    vecs[0] = '{4'b0001, 1'b1, 8'd3, 1'b0, -1, 0,  1'b0, 4,  4'b1000};
    vecs[1] = '{4'b1000, 1'b0, 8'd3, 1'b0, -1, 0,  1'b0, 4,  4'b0001};
    vecs[2] = '{4'b0011, 1'b1, 8'd1, 1'b0, -1, 0,  1'b0, 4,  4'b0110};
    vecs[3] = '{4'b1001, 1'b0, 8'd2, 1'b0, -1, 0,  1'b0, 4,  4'b0110};
    vecs[4] = '{4'b0001, 1'b1, 8'd2, 1'b0,  2, 10, 1'b0, 14, 4'b0100};
    vecs[5] = '{4'b0110, 1'b1, 8'd2, 1'b0,  3, 3,  1'b0, 7,  4'b1001};
    vecs[6] = '{4'b0101, 1'b1, 8'd5, 1'b0,  0, 1,  1'b0, 4,  4'b1010};
    vecs[7] = '{4'b1110, 1'b0, 8'd4, 1'b0, -1, 0,  1'b1, 4,  4'b1110};
    vecs[8] = '{4'b0001, 1'b1, 8'd8, 1'b1, -1, 0,  1'b0, 4,  4'b0001};

    rst = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_pattern = '0;
    cmd_if.cmd_dir     = 1'b0;
    cmd_if.cmd_steps   = '0;
    cmd_if.cmd_bounce  = 1'b0;

    #3;
    checkOutput("rst_load_n", rot_load_n, 0);
    checkOutput("rst_rot_load", rot_load, 0);
    checkOutput("rst_rot_en", rot_en, 0);
    checkOutput("rst_rot_dir", rot_dir, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ready", cmd_if.cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("idle_load_n", rot_load_n, 1);
    checkOutput("idle_rot", rot, 0);

    for (int i = 0; i < 9; i++) runVector(i, vecs[i]);

    $display("[TB] continuous scroll then abort");
    applyStimulus(4'b1000, 1'b0, 8'd0, 1'b0);
    c = 0;
    pulses = 0;
    while (pulses < 8 && c < 100) begin
      tick();
      c++;
      if (rot_en) pulses++;
      checkOutput("cont_no_done", done, 0);
    end
    checkOutput("cont_pulses", pulses, 8);
    tick();
    checkOutput("cont_rot_after8", rot, 4'b1000);
    checkOutput("cont_busy", busy, 1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_ready", cmd_if.cmd_ready, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_beats_step", rot_en, 0);
    checkOutput("abort_no_done", done, 0);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rot_en || done) stray++;
    end
    checkOutput("abort_quiet", stray, 0);
    checkOutput("abort_rot_kept", rot, 4'b1000);

    $display("[TB] abort during LOAD");
    applyStimulus(4'b0101, 1'b1, 8'd2, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("lab_ready", cmd_if.cmd_ready, 1);
    checkOutput("lab_load_n", rot_load_n, 1);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rot_en || done) stray++;
    end
    checkOutput("lab_quiet", stray, 0);
    checkOutput("lab_rot", rot, 4'b0101);

    $display("[TB] reset in the middle of a scroll");
    applyStimulus(4'b0011, 1'b1, 8'd0, 1'b0);
    c = 0;
    while (!rot_en && c < 20) begin
      tick();
      c++;
    end
    checkOutput("mid_pulse_seen", rot_en, 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_en", rot_en, 0);
    checkOutput("mid_rst_load_n", rot_load_n, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_ready", cmd_if.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_ready", cmd_if.cmd_ready, 1);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_load_n", rot_load_n, 1);
    checkOutput("post_rst_rot", rot, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
